// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target blocks.
package i2c_target_pkg;

    typedef enum logic [4:0] {
        IDLE     = 5'd0,
        ADDR     = 5'd1,
        ADDR_ACK = 5'd2,
        WR_DATA  = 5'd3,
        WR_ACK   = 5'd4,
        RD_DATA  = 5'd5,
        RD_ACK   = 5'd6,
        IGNORE   = 5'd7
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam int   ADDR_W   = 5;
    localparam int   BYTE_W   = 8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and flags line edges and START/STOP.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_q;
    logic                   sda_q;

    // Synchronizer chains plus one extra stage for edge detection; idle lines are high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_q    <= scl_sync[SYNC_STAGES-1];
            sda_q    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl       = scl_sync[SYNC_STAGES-1];
    assign sda       = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_q;
    assign scl_fall  = ~scl & scl_q;
    assign start_det = scl & scl_q & sda_q & ~sda;
    assign stop_det  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_target_memory.sv
// I2C target with a small register memory: address match, byte writes, burst reads.
module i2c_target_memory
    import i2c_target_pkg::*;
#(
    parameter logic [1:0] DEV_ID      = 2'd1,
    parameter int         MEM_DEPTH   = 32,
    parameter int         DATA_WIDTH  = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BYTE_W-1:0] wr_data,
    output logic [4:0]        state
);

    logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t                  st, st_next;
    logic [3:0]              bit_cnt, bit_cnt_next;
    logic [DATA_WIDTH-1:0]   shreg, shreg_next;
    logic [ADDR_W-1:0]       addr, addr_next, rd_addr;
    logic                    rw, rw_next;
    logic                    ack_phase, ack_phase_next;
    logic                    sda_oe_next, busy_next, wr_valid_next;
    logic [ADDR_W-1:0]       wr_addr_next;
    logic [BYTE_W-1:0]       wr_data_next;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   rd_data;

    // The read port looks one address ahead while waiting for the master's read ACK.
    assign rd_addr = (st == RD_ACK) ? ADDR_W'(addr + 1'b1) : addr;
    assign rd_data = mem[rd_addr];
    assign state   = st;

    // Memory array: cleared on reset, written only when a received byte is committed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[addr] <= shreg;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            addr      <= '0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            st        <= st_next;
            bit_cnt   <= bit_cnt_next;
            shreg     <= shreg_next;
            addr      <= addr_next;
            rw        <= rw_next;
            ack_phase <= ack_phase_next;
            sda_oe    <= sda_oe_next;
            busy      <= busy_next;
            wr_valid  <= wr_valid_next;
            wr_addr   <= wr_addr_next;
            wr_data   <= wr_data_next;
        end
    end

    // Next-state logic; STOP outranks START, both outrank any bit-level activity.
    always_comb begin
        st_next        = st;
        bit_cnt_next   = bit_cnt;
        shreg_next     = shreg;
        addr_next      = addr;
        rw_next        = rw;
        ack_phase_next = ack_phase;
        sda_oe_next    = sda_oe;
        busy_next      = busy;
        wr_valid_next  = 1'b0;
        wr_addr_next   = wr_addr;
        wr_data_next   = wr_data;
        mem_we         = 1'b0;

        if (stop_det) begin
            st_next      = IDLE;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
        end else if (start_det) begin
            st_next      = ADDR;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
        end else begin
            case (st)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shreg_next   = {shreg[DATA_WIDTH-2:0], sda};
                        bit_cnt_next = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (shreg[6:5] == DEV_ID) begin
                                addr_next      = shreg[4:0];
                                rw_next        = sda;
                                ack_phase_next = 1'b0;
                                busy_next      = 1'b1;
                                st_next        = ADDR_ACK;
                            end else begin
                                st_next = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_next    = ~I2C_ACK;
                            ack_phase_next = 1'b1;
                        end else if (!rw) begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = '0;
                            st_next      = WR_DATA;
                        end else begin
                            sda_oe_next  = ~rd_data[DATA_WIDTH-1];
                            shreg_next   = {rd_data[DATA_WIDTH-2:0], 1'b0};
                            bit_cnt_next = 4'd1;
                            st_next      = RD_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shreg_next   = {shreg[DATA_WIDTH-2:0], sda};
                        bit_cnt_next = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        mem_we        = 1'b1;
                        wr_valid_next = 1'b1;
                        wr_addr_next  = addr;
                        wr_data_next  = shreg;
                        sda_oe_next   = ~I2C_ACK;
                        addr_next     = ADDR_W'(addr + 1'b1);
                        st_next       = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = '0;
                        st_next      = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_next = 1'b0;
                            st_next     = RD_ACK;
                        end else begin
                            sda_oe_next  = ~shreg[DATA_WIDTH-1];
                            shreg_next   = {shreg[DATA_WIDTH-2:0], 1'b0};
                            bit_cnt_next = bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda == I2C_NACK) begin
                            busy_next = 1'b0;
                            st_next   = IGNORE;
                        end else begin
                            addr_next    = rd_addr;
                            shreg_next   = rd_data;
                            bit_cnt_next = '0;
                            st_next      = RD_DATA;
                        end
                    end
                end
                IGNORE: sda_oe_next = 1'b0;
                default: st_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_memory.sv
// Self-checking bench: bit-banged I2C master, write scoreboard and memory model.
module tb_i2c_target_memory;
    import i2c_target_pkg::*;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       sda_oe, busy, wr_valid;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] state;

    int         checks = 0;
    int         errors = 0;
    logic [12:0] wr_q [$];
    logic [7:0]  model_mem [32];
    logic        sda_oe_seen = 1'b0;

    assign sda_line = m_sda & ~sda_oe;

    i2c_target_memory dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (m_scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .state    (state)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every committed byte must match the oldest expected write.
    always @(negedge clk) begin
        if (sda_oe) sda_oe_seen = 1'b1;
        if (reset && wr_valid) begin
            if (wr_q.size() == 0) begin
                checkOutput("wr_unexpected", {31'd0, wr_valid}, 32'd0);
            end else begin
                logic [12:0] e;
                e = wr_q.pop_front();
                checkOutput("wr_addr", {27'd0, wr_addr}, {27'd0, e[12:8]});
                checkOutput("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(posedge clk);
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        model_mem[a] = d;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        b = sda_line; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(nack);
    endtask

    task automatic read_burst(input logic [4:0] a, input int n);
        logic       ack;
        logic [7:0] d;
        logic [4:0] idx;
        i2c_start();
        write_byte({2'd1, a, 1'b1}, ack);
        checkOutput("rd_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < n; i++) begin
            read_byte(d, (i == n - 1));
            idx = a + i[4:0];
            checkOutput("rd_data", {24'd0, d}, {24'd0, model_mem[idx]});
        end
        i2c_stop();
    endtask

    initial begin
        logic ack;
        logic [7:0] d;
        for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;

        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        checkOutput("rst_state", {27'd0, state}, {27'd0, IDLE});
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_wr_valid", {31'd0, wr_valid}, 32'd0);
        checkOutput("idle_wr_addr", {27'd0, wr_addr}, 32'd0);
        checkOutput("idle_wr_data", {24'd0, wr_data}, 32'd0);

        // Write 0x05 to address 1.
        i2c_start();
        write_byte(8'h42, ack);
        checkOutput("w1_addr_ack", {31'd0, ack}, 32'd0);
        checkOutput("w1_busy", {31'd0, busy}, 32'd1);
        expect_write(5'd1, 8'h05);
        write_byte(8'h05, ack);
        checkOutput("w1_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        checkOutput("w1_busy_stop", {31'd0, busy}, 32'd0);
        checkOutput("w1_state_stop", {27'd0, state}, {27'd0, IDLE});

        // Single read with NACK: passes through IGNORE, then IDLE at STOP.
        i2c_start();
        write_byte(8'h43, ack);
        checkOutput("r1_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(d, 1'b1);
        checkOutput("r1_data", {24'd0, d}, {24'd0, model_mem[1]});
        checkOutput("r1_state_nack", {27'd0, state}, {27'd0, IGNORE});
        checkOutput("r1_busy_nack", {31'd0, busy}, 32'd0);
        i2c_stop();
        checkOutput("r1_state_stop", {27'd0, state}, {27'd0, IDLE});

        // Wrong device ID: no ACK, no drive, no commit.
        sda_oe_seen = 1'b0;
        i2c_start();
        write_byte(8'h82, ack);
        checkOutput("wd_addr_nack", {31'd0, ack}, 32'd1);
        write_byte(8'h77, ack);
        checkOutput("wd_data_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        checkOutput("wd_sda_oe_seen", {31'd0, sda_oe_seen}, 32'd0);
        read_burst(5'd1, 1);

        // Wrap-around burst write from address 31, then burst read back.
        i2c_start();
        write_byte(8'h7E, ack);
        checkOutput("wrap_addr_ack", {31'd0, ack}, 32'd0);
        expect_write(5'd31, 8'hAA);
        write_byte(8'hAA, ack);
        expect_write(5'd0, 8'hBB);
        write_byte(8'hBB, ack);
        expect_write(5'd1, 8'hCC);
        write_byte(8'hCC, ack);
        checkOutput("wrap_last_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        read_burst(5'd31, 3);

        // Repeated START after half a data byte discards it.
        i2c_start();
        write_byte(8'h42, ack);
        for (int i = 0; i < 4; i++) write_bit(i[0]);
        i2c_start();
        checkOutput("rs_state_addr", {27'd0, state}, {27'd0, ADDR});
        write_byte(8'h44, ack);
        checkOutput("rs_addr_ack", {31'd0, ack}, 32'd0);
        expect_write(5'd2, 8'h5A);
        write_byte(8'h5A, ack);
        i2c_stop();
        read_burst(5'd1, 2);

        // Asynchronous reset while driving a read bit low.
        i2c_start();
        write_byte(8'h45, ack);
        checkOutput("ar_addr_ack", {31'd0, ack}, 32'd0);
        checkOutput("ar_pre_sda_oe", {31'd0, sda_oe}, 32'd1);
        checkOutput("ar_pre_state", {27'd0, state}, {27'd0, RD_DATA});
        reset = 1'b0;
        #1;
        checkOutput("ar_sda_oe", {31'd0, sda_oe}, 32'd0);
        checkOutput("ar_state", {27'd0, state}, {27'd0, IDLE});
        for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
        m_scl = 1'b1;
        m_sda = 1'b1;
        wait_q();
        reset = 1'b1;
        wait_q();
        read_burst(5'd1, 2);

        checkOutput("wr_queue_empty", wr_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
